// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for the 5-stage core.
// Arbitrates halt, data-miss wait, EX redirect, load-use and fetch-miss
// into per-stage enables and flushes. Small FSM tracks RUN/DWAIT/HALTED.
// Optional build macro HAZARD_CTRL_PERF_EN adds saturating 32-bit
// stall_cnt / flush_cnt performance counters.
module hazard_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_wsel,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        ex_redirect,
    input  logic        wb_halt,
    output logic        pc_EN,
    output logic        ifid_EN,
    output logic        ifid_flush,
    output logic        idex_EN,
    output logic        idex_flush,
    output logic        exmem_EN,
    output logic        exmem_flush,
    output logic        memwb_EN,
    output logic        halted,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2,
        BAD    = 2'd3
    } state_t;

    state_t cur, nxt;
    logic   memstall, loaduse;
    logic   redir_evt;

    assign memstall = (mem_dREN | mem_dWEN) & ~dhit;
    // r0 is never a real dependency, so a load into r0 never stalls
    assign loaduse  = ex_dREN & (ex_wsel != 5'd0) &
                      ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));
    assign state    = cur;

    // Priority arbitration of stage controls and next state
    always_comb begin
        pc_EN       = 1'b0;
        ifid_EN     = 1'b0;
        ifid_flush  = 1'b0;
        idex_EN     = 1'b0;
        idex_flush  = 1'b0;
        exmem_EN    = 1'b0;
        exmem_flush = 1'b0;
        memwb_EN    = 1'b0;
        redir_evt   = 1'b0;
        nxt         = cur;
        if (RST) begin
            // hold everything and squash the front of the pipe
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            nxt         = RUN;
        end else begin
            case (cur)
                RUN: begin
                    if (wb_halt) begin
                        nxt = HALTED;
                    end else if (memstall) begin
                        nxt = DWAIT;
                    end else if (ex_redirect) begin
                        // squashes any younger load-use victim as well
                        {pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN} = '1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        redir_evt  = 1'b1;
                    end else if (loaduse) begin
                        // freeze PC/IFID, insert one bubble into IDEX
                        idex_EN    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_EN   = 1'b1;
                        memwb_EN   = 1'b1;
                    end else if (!ihit) begin
                        // fetch not back yet: hold PC, bubble into IFID
                        {ifid_EN, idex_EN, exmem_EN, memwb_EN} = '1;
                        ifid_flush = 1'b1;
                    end else begin
                        {pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN} = '1;
                    end
                end
                DWAIT: begin
                    // release once the data side completes; ihit not consulted
                    if (!memstall) begin
                        {pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN} = '1;
                        nxt = RUN;
                    end
                end
                HALTED: nxt = HALTED;
                default: nxt = RUN;
            endcase
        end
    end

    // State register and registered halted flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur    <= RUN;
            halted <= 1'b0;
        end else begin
            cur    <= nxt;
            halted <= (nxt == HALTED);
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic stall_evt;
    assign stall_evt = ((cur == RUN) | (cur == DWAIT)) & ~pc_EN;

    // Saturating stall / redirect-flush counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (redir_evt && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven checks of the RUN-state arbitration plus
// hand-written sequences for data-miss wait, halt and reset corners.
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rt;
    logic        ex_dREN;
    logic [4:0]  ex_wsel;
    logic        mem_dREN, mem_dWEN;
    logic        ex_redirect, wb_halt;
    logic        pc_EN, ifid_EN, ifid_flush, idex_EN, idex_flush;
    logic        exmem_EN, exmem_flush, memwb_EN, halted;
    logic [1:0]  state;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_EN(pc_EN), .ifid_EN(ifid_EN), .ifid_flush(ifid_flush),
        .idex_EN(idex_EN), .idex_flush(idex_flush),
        .exmem_EN(exmem_EN), .exmem_flush(exmem_flush),
        .memwb_EN(memwb_EN), .halted(halted),
`ifdef HAZARD_CTRL_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .state(state)
    );

    // {pc_EN, ifid_EN, ifid_flush, idex_EN, idex_flush, exmem_EN, exmem_flush, memwb_EN}
    function automatic logic [7:0] ctl();
        return {pc_EN, ifid_EN, ifid_flush, idex_EN, idex_flush,
                exmem_EN, exmem_flush, memwb_EN};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_dREN = 1'b0; ex_wsel = 5'd0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_redirect = 1'b0; wb_halt = 1'b0;
    endtask

    // advance one clock, land 1 time unit after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        string      name;
        logic       ihit, dhit, uses_rt, ex_dren, mem_dren, redir;
        logic [4:0] rs, rt, wsel;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[11];

    localparam logic [7:0] C_RUN   = 8'b1101_0101;
    localparam logic [7:0] C_IMISS = 8'b0111_0101;
    localparam logic [7:0] C_LU    = 8'b0001_1101;
    localparam logic [7:0] C_REDIR = 8'b1111_1101;
    localparam logic [7:0] C_HOLD  = 8'b0000_0000;
    localparam logic [7:0] C_RST   = 8'b0010_1010;

    initial begin
        //              name       ihit dhit urt dren mrd red rs     rt     wsel
        vt[0]  = '{"idle",        1,0, 0,0,0,0, 5'd0, 5'd0, 5'd0, C_RUN};
        vt[1]  = '{"imiss",       0,0, 0,0,0,0, 5'd0, 5'd0, 5'd0, C_IMISS};
        vt[2]  = '{"lu_rs",       1,0, 0,1,0,0, 5'd8, 5'd0, 5'd8, C_LU};
        vt[3]  = '{"lu_r0",       1,0, 0,1,0,0, 5'd0, 5'd0, 5'd0, C_RUN};
        vt[4]  = '{"lu_rt",       1,0, 1,1,0,0, 5'd3, 5'd5, 5'd5, C_LU};
        vt[5]  = '{"rt_unused",   1,0, 0,1,0,0, 5'd3, 5'd5, 5'd5, C_RUN};
        vt[6]  = '{"no_load",     1,0, 1,0,0,0, 5'd8, 5'd8, 5'd8, C_RUN};
        vt[7]  = '{"redir",       1,0, 0,0,0,1, 5'd0, 5'd0, 5'd0, C_REDIR};
        vt[8]  = '{"redir_lu_im", 0,0, 0,1,0,1, 5'd9, 5'd0, 5'd9, C_REDIR};
        vt[9]  = '{"lu_imiss",    0,0, 0,1,0,0, 5'd9, 5'd0, 5'd9, C_LU};
        vt[10] = '{"dread_hit",   1,1, 0,0,1,0, 5'd0, 5'd0, 5'd0, C_RUN};

        idle();
        RST = 1'b1;
        #1;
        chk("rst_ctl", {24'd0, ctl()}, {24'd0, C_RST});
        tick();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
`ifdef HAZARD_CTRL_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        RST = 1'b0;
        tick();

        // RUN-state arbitration table; none of these leave RUN
        for (int i = 0; i < 11; i++) begin
            ihit = vt[i].ihit; dhit = vt[i].dhit; id_uses_rt = vt[i].uses_rt;
            ex_dREN = vt[i].ex_dren; mem_dREN = vt[i].mem_dren;
            ex_redirect = vt[i].redir; id_rs = vt[i].rs; id_rt = vt[i].rt;
            ex_wsel = vt[i].wsel;
            #2;
            chk(vt[i].name, {24'd0, ctl()}, {24'd0, vt[i].exp});
            tick();
            chk({vt[i].name, "_state"}, {30'd0, state}, 32'd0);
        end
        idle();
`ifdef HAZARD_CTRL_PERF_EN
        // pc stalls: imiss, lu_rs, lu_rt, lu_imiss; flushes: redir, redir_lu_im
        chk("tbl_stall_cnt", stall_cnt, 32'd4);
        chk("tbl_flush_cnt", flush_cnt, 32'd2);
`endif

        // data miss: three missing cycles then hit
        mem_dREN = 1'b1; dhit = 1'b0;
        #2;
        chk("miss1_ctl", {24'd0, ctl()}, {24'd0, C_HOLD});
        tick();
        for (int c = 2; c <= 3; c++) begin
            chk($sformatf("miss%0d_state", c), {30'd0, state}, 32'd1);
            chk($sformatf("miss%0d_ctl", c), {24'd0, ctl()}, {24'd0, C_HOLD});
            tick();
        end
        dhit = 1'b1; ihit = 1'b0;
        #2;
        chk("miss_done_state", {30'd0, state}, 32'd1);
        chk("miss_done_ctl", {24'd0, ctl()}, {24'd0, 8'b1101_0101});
        tick();
        idle();
        chk("miss_back_run", {30'd0, state}, 32'd0);
`ifdef HAZARD_CTRL_PERF_EN
        chk("miss_stall_cnt", stall_cnt, 32'd7);
`endif

        // halt is sticky for 10 cycles
        wb_halt = 1'b1;
        #2;
        chk("halt_ctl", {24'd0, ctl()}, {24'd0, C_HOLD});
        tick();
        idle();
        ex_redirect = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("halt%0d", c),
                {21'd0, state, halted, ctl()}, {21'd0, 2'd2, 1'b1, C_HOLD});
            tick();
        end
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("halt_rst", {30'd0, state, halted}, {30'd0, 2'd0, 1'b0});
        tick();

        // reset arriving in the middle of a data wait
        mem_dWEN = 1'b1; dhit = 1'b0;
        tick();
        chk("dw_state", {30'd0, state}, 32'd1);
        RST = 1'b1;
        #1;
        chk("dw_rst_ctl", {24'd0, ctl()}, {24'd0, C_RST});
        tick();
        chk("dw_rst_state", {30'd0, state}, 32'd0);
`ifdef HAZARD_CTRL_PERF_EN
        chk("dw_stall_cnt", stall_cnt, 32'd0);
        chk("dw_flush_cnt", flush_cnt, 32'd0);
`endif
        RST = 1'b0;
        idle();
        #2;
        chk("post_rst_ctl", {24'd0, ctl()}, {24'd0, C_RUN});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have: RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: ihit  in  1  instruction fetch complete this cycle; dhit  in  1  data access complete this cycle.
REQ-004 SHALL have: id_rs, id_rt  in  5 each  decode-stage source registers; id_uses_rt  in  1  decode instruction reads rt.
REQ-005 SHALL have: ex_dREN  in  1, ex_wsel  in  5  load flag and destination register held in ID/EX stage.
REQ-006 SHALL have: mem_dREN, mem_dWEN  in  1 each  data request pending in EX/MEM stage.
REQ-007 SHALL have: ex_redirect  in  1  branch taken or jump resolved in EX; wb_halt  in  1  halt reached writeback.
REQ-008 SHALL have outputs (1 bit each): pc_EN, ifid_EN, ifid_flush, idex_EN, idex_flush, exmem_EN, exmem_flush, memwb_EN, halted; state  out  2  current FSM state.

Function
REQ-009 SHALL implement FSM states RUN=0, DWAIT=1, HALTED=2; encoding 3 unused, SHALL go to RUN next cycle.
REQ-010 SHALL define memstall = (mem_dREN | mem_dWEN) & ~dhit; loaduse = ex_dREN & (ex_wsel != 0) & ((ex_wsel == id_rs) | (id_uses_rt & ex_wsel == id_rt)).
REQ-011 RUN, wb_halt=1: SHALL drive all EN 0, all flush 0, next state HALTED (highest priority).
REQ-012 RUN/DWAIT, memstall=1: SHALL drive all EN 0, all flush 0; next state DWAIT.
REQ-013 DWAIT, dhit=1: SHALL drive all EN 1 this cycle, next state RUN; ihit ignored in DWAIT.
REQ-014 RUN, ex_redirect=1 (no memstall): SHALL drive all EN 1, ifid_flush=1, idex_flush=1, exmem_flush=0.
REQ-015 RUN, loaduse=1 (no memstall, no redirect): SHALL drive pc_EN=0, ifid_EN=0, idex_flush=1, exmem_EN=1, memwb_EN=1 -- exactly one bubble per hazard.
REQ-016 RUN, ~ihit (none of above): SHALL drive pc_EN=0, ifid_flush=1, all other EN 1.
REQ-017 RUN, otherwise: SHALL drive all EN 1, all flush 0.
REQ-018 Priority SHALL be wb_halt > memstall > ex_redirect > loaduse > ~ihit.
REQ-019 Redirect with simultaneous loaduse SHALL flush, not stall (loaduse instruction is squashed).
REQ-020 HALTED SHALL be sticky: all EN 0, all flush 0, halted=1 until RST.
REQ-021 All outputs except state and halted SHALL be combinational from state and inputs, zero-cycle latency.

Reset
REQ-022 RST high at an edge SHALL set state=RUN, halted=0, counters=0, regardless of current state (including DWAIT and HALTED).
REQ-023 While RST high, SHALL drive all EN 0 and ifid_flush, idex_flush, exmem_flush 1.

Configuration
REQ-024 Macro HAZARD_CTRL_PERF_EN defined: SHALL add outputs stall_cnt  out  32  and flush_cnt  out  32.
REQ-025 stall_cnt SHALL increment each non-reset cycle pc_EN=0 in RUN or DWAIT; flush_cnt SHALL increment each cycle REQ-014 applies; both saturate at 32'hFFFFFFFF.
REQ-026 Macro undefined: SHALL omit both ports and counters; all other behaviour identical.

Verification
REQ-027 Load-use: ex_dREN=1, ex_wsel=8, id_rs=8, ihit=1 -> pc_EN=0, ifid_EN=0, idex_flush=1 for one cycle; ex_wsel=0, id_rs=0 -> no stall.
REQ-028 Data miss: mem_dREN=1, dhit=0 for 3 cycles then 1 -> state DWAIT cycles 2-3, all EN 0, then all EN 1, state RUN.
REQ-029 Redirect with loaduse and ~ihit same cycle -> ifid_flush=1, idex_flush=1, pc_EN=1, flush_cnt +1.
REQ-030 wb_halt=1 -> state HALTED, halted=1, all EN 0 held for 10 cycles; RST pulse -> state RUN, halted=0.
REQ-031 RST asserted mid-DWAIT -> state RUN next edge, flushes 1 during reset; with HAZARD_CTRL_PERF_EN, counters read 0.
